// File: rtl/conv_ctrl_if.sv
// Host/datapath-facing signal bundle of the 1-D convolution sequencer.
// The slave modport is the controller itself; the master modport is the
// host/datapath side that drives start and sizes and consumes the strobes.
interface conv_ctrl_if #(
    parameter int SIZE_W  = 5,
    parameter int ZADDR_W = 6
);
    logic               start_i;
    logic [SIZE_W-1:0]  size_x_i;
    logic [SIZE_W-1:0]  size_y_i;
    logic               size_en_o;
    logic               size_clr_o;
    logic [SIZE_W-1:0]  memx_addr_o;
    logic [SIZE_W-1:0]  memy_addr_o;
    logic [ZADDR_W-1:0] memz_addr_o;
    logic               memz_we_o;
    logic               acc_clr_o;
    logic               acc_en_o;
    logic               busy_o;
    logic               done_o;

    modport slave (
        input  start_i, size_x_i, size_y_i,
        output size_en_o, size_clr_o, memx_addr_o, memy_addr_o, memz_addr_o,
               memz_we_o, acc_clr_o, acc_en_o, busy_o, done_o
    );

    modport master (
        output start_i, size_x_i, size_y_i,
        input  size_en_o, size_clr_o, memx_addr_o, memy_addr_o, memz_addr_o,
               memz_we_o, acc_clr_o, acc_en_o, busy_o, done_o
    );
endinterface

// File: rtl/conv_ctrl.sv
// Sequencing FSM for the 1-D convolution core Z[i] = sum_k X[k]*Y[i-k].
// For every output index i it clears the accumulator, walks k over the full
// X length issuing X/Y reads, lets the last read drain through the one-cycle
// memory latency, then writes Z[i]. Strobes are decoded from the state.
module conv_ctrl #(
    parameter int SIZE_W  = 5,
    parameter int ZADDR_W = 6
) (
    input  logic       clk,
    input  logic       rstn,
    conv_ctrl_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_CLR   = 3'd2;
    localparam logic [2:0] S_MAC   = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_WRITE = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    // One extra bit so index arithmetic never wraps when comparing.
    localparam int DW  = ZADDR_W + 1;
    localparam int PAD = DW - SIZE_W;

    logic [2:0]         state;
    logic [ZADDR_W-1:0] i;
    logic [ZADDR_W-1:0] z_hold;
    logic [SIZE_W-1:0]  k;
    logic [SIZE_W-1:0]  sx;
    logic [SIZE_W-1:0]  sy;
    logic [SIZE_W-1:0]  x_hold;
    logic [SIZE_W-1:0]  y_hold;
    logic               valid_q;

    logic [DW-1:0]      i_ext;
    logic [DW-1:0]      k_ext;
    logic [DW-1:0]      y_idx;
    logic [DW-1:0]      last_i;
    logic               tap_valid;
    logic               last_tap;
    logic               last_out;
    logic               zero_size;

    assign i_ext     = {1'b0, i};
    assign k_ext     = {{PAD{1'b0}}, k};
    assign y_idx     = i_ext - k_ext;
    assign last_i    = {{PAD{1'b0}}, sx} + {{PAD{1'b0}}, sy} - DW'(2);
    // A tap contributes only when Y[i-k] exists: k<=i and i-k below the Y length.
    assign tap_valid = (state == S_MAC) && (k_ext <= i_ext) && (y_idx < {{PAD{1'b0}}, sy});
    assign last_tap  = (k == sx - SIZE_W'(1));
    assign last_out  = (i_ext == last_i);
    assign zero_size = (bus.size_x_i == '0) || (bus.size_y_i == '0);

    // State, loop indices, latched sizes, read-valid pipe and held addresses.
    // NOTE: every register here uses <= so all of them update from the same
    // pre-edge values; a blocking = would let later lines see half-updated state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= S_IDLE;
            i       <= '0;
            k       <= '0;
            sx      <= '0;
            sy      <= '0;
            valid_q <= 1'b0;
            x_hold  <= '0;
            y_hold  <= '0;
            z_hold  <= '0;
        end else begin
            // Reads issued this cycle return next cycle, so the accumulate
            // enable lags the tap decision by one cycle.
            valid_q <= tap_valid;
            case (state)
                S_IDLE: begin
                    if (bus.start_i) state <= S_LOAD;
                end
                S_LOAD: begin
                    sx    <= bus.size_x_i;
                    sy    <= bus.size_y_i;
                    i     <= '0;
                    state <= zero_size ? S_DONE : S_CLR;
                end
                S_CLR: begin
                    k     <= '0;
                    state <= S_MAC;
                end
                S_MAC: begin
                    x_hold <= k;
                    y_hold <= y_idx[SIZE_W-1:0];
                    if (last_tap) state <= S_DRAIN;
                    else          k     <= k + SIZE_W'(1);
                end
                S_DRAIN: begin
                    state <= S_WRITE;
                end
                S_WRITE: begin
                    z_hold <= i;
                    if (last_out) begin
                        state <= S_DONE;
                    end else begin
                        i     <= i + ZADDR_W'(1);
                        state <= S_CLR;
                    end
                end
                S_DONE: begin
                    sx    <= '0;
                    sy    <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.size_en_o   = (state == S_LOAD);
    assign bus.size_clr_o  = (state == S_DONE);
    assign bus.memx_addr_o = (state == S_MAC)   ? k                 : x_hold;
    assign bus.memy_addr_o = (state == S_MAC)   ? y_idx[SIZE_W-1:0] : y_hold;
    assign bus.memz_addr_o = (state == S_WRITE) ? i                 : z_hold;
    assign bus.memz_we_o   = (state == S_WRITE);
    assign bus.acc_clr_o   = (state == S_CLR);
    assign bus.acc_en_o    = valid_q;
    assign bus.busy_o      = (state != S_IDLE);
    assign bus.done_o      = (state == S_DONE);
endmodule

// File: tb/tb_conv_ctrl.sv
// Self-checking bench for conv_ctrl: a per-run schedule of expected outputs
// derived from the convolution rules, compared on every falling edge, plus
// hand-computed literals for done latency, write counts and tap counts.
module tb_conv_ctrl;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    conv_ctrl_if #(.SIZE_W(5), .ZADDR_W(6)) bus ();
    conv_ctrl #(.SIZE_W(5), .ZADDR_W(6)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    typedef struct packed {
        logic       size_en;
        logic       size_clr;
        logic [4:0] xa;
        logic [4:0] ya;
        logic [5:0] za;
        logic       we;
        logic       clr;
        logic       en;
        logic       busy;
        logic       done;
    } out_t;

    out_t       exp_q[$];
    int         vectors = 0;
    int         fails   = 0;
    logic [4:0] hx = '0;
    logic [4:0] hy = '0;
    logic [5:0] hz = '0;
    int         cyc, done_cycle, we_count, last_za, en_count, en_acc;
    int         en_per_out[$];
    int         pairs2[$];
    logic [4:0] prev_xa = '0;
    logic [4:0] prev_ya = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic out_t idle_entry();
        out_t e;
        e    = '0;
        e.xa = hx;
        e.ya = hy;
        e.za = hz;
        return e;
    endfunction

    function automatic out_t sample();
        out_t s;
        s.size_en  = bus.size_en_o;
        s.size_clr = bus.size_clr_o;
        s.xa       = bus.memx_addr_o;
        s.ya       = bus.memy_addr_o;
        s.za       = bus.memz_addr_o;
        s.we       = bus.memz_we_o;
        s.clr      = bus.acc_clr_o;
        s.en       = bus.acc_en_o;
        s.busy     = bus.busy_o;
        s.done     = bus.done_o;
        return s;
    endfunction

    // Expected cycle-by-cycle schedule of one run, starting with the cycle
    // after the start-sampling edge: load, then per output a clear, x taps,
    // a drain and a write, then done, then one idle cycle.
    task automatic build(input int x, input int y);
        out_t e;
        bit   pv;
        cyc = 0; done_cycle = -1; we_count = 0; last_za = -1;
        en_count = 0; en_acc = 0;
        en_per_out.delete();
        pairs2.delete();
        e = idle_entry(); e.busy = 1; e.size_en = 1; exp_q.push_back(e);
        if (x > 0 && y > 0) begin
            for (int i = 0; i <= x + y - 2; i++) begin
                e = idle_entry(); e.busy = 1; e.clr = 1; exp_q.push_back(e);
                pv = 0;
                for (int k = 0; k < x; k++) begin
                    hx = 5'(k);
                    hy = 5'(i - k);
                    e = idle_entry(); e.busy = 1; e.en = pv; exp_q.push_back(e);
                    pv = (k <= i) && (i - k < y);
                end
                e = idle_entry(); e.busy = 1; e.en = pv; exp_q.push_back(e);
                hz = 6'(i);
                e = idle_entry(); e.busy = 1; e.we = 1; exp_q.push_back(e);
            end
        end
        e = idle_entry(); e.busy = 1; e.done = 1; e.size_clr = 1; exp_q.push_back(e);
        exp_q.push_back(idle_entry());
    endtask

    // Single compare process: every falling edge, DUT outputs vs the schedule.
    always @(negedge clk) begin
        out_t got, want;
        got = sample();
        cyc++;
        if (exp_q.size() > 0) want = exp_q.pop_front();
        else                  want = idle_entry();
        check("cycle", 64'(got), 64'(want));
        if (got.done) done_cycle = cyc;
        if (got.en) begin
            en_count++;
            en_acc++;
            if (we_count == 2) pairs2.push_back(int'(prev_xa) * 100 + int'(prev_ya));
        end
        if (got.we) begin
            we_count++;
            last_za = int'(got.za);
            en_per_out.push_back(en_acc);
            en_acc = 0;
        end
        prev_xa = got.xa;
        prev_ya = got.ya;
    end

    task automatic run(input int x, input int y, input bit keep, input bit scramble, input int abort_at);
        int budget;
        int n;
        budget = (x + y + 1) * (x + 3) + 10;
        n      = 0;
        bus.size_x_i = 5'(x);
        bus.size_y_i = 5'(y);
        bus.start_i  = 1'b1;
        @(posedge clk);
        build(x, y);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            #1;
            n++;
            if (!keep) bus.start_i = 1'b0;
            if (scramble && n >= 2) begin
                bus.size_x_i = 5'($urandom_range(0, 31));
                bus.size_y_i = 5'($urandom_range(0, 31));
            end
            if (abort_at != 0 && n == abort_at) begin
                rstn = 1'b0;
                exp_q.delete();
                hx = '0; hy = '0; hz = '0;
                #1;
                check("async_reset", 64'(sample()), 64'(idle_entry()));
                @(negedge clk);
                #1;
                rstn = 1'b1;
            end
            if (n > budget && exp_q.size() > 0) begin
                vectors++;
                fails++;
                $display("FAIL timeout: run %0dx%0d still pending after %0d cycles, expected completion", x, y, n);
                exp_q.delete();
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        bus.start_i  = 1'b0;
        bus.size_x_i = '0;
        bus.size_y_i = '0;
        repeat (2) @(negedge clk);
        #1;
        rstn = 1'b1;
        check("reset_busy", 64'(bus.busy_o), 64'(0));

        // Reset mid-MAC of a 3x2 run (cycle 5 is the third tap of i=0).
        run(3, 2, 1'b0, 1'b0, 5);
        check("abort_busy", 64'(bus.busy_o), 64'(0));

        // 1x1: single output.
        run(1, 1, 1'b0, 1'b0, 0);
        check("1x1_done_cycle", 64'(done_cycle), 64'(6));
        check("1x1_writes", 64'(we_count), 64'(1));
        check("1x1_last_addr", 64'(last_za), 64'(0));
        check("1x1_acc_en", 64'(en_count), 64'(1));

        // 3x2: four outputs with taps 1,2,2,1.
        run(3, 2, 1'b0, 1'b0, 0);
        check("3x2_done_cycle", 64'(done_cycle), 64'(26));
        check("3x2_writes", 64'(we_count), 64'(4));
        check("3x2_last_addr", 64'(last_za), 64'(3));
        check("3x2_out_count", 64'(en_per_out.size()), 64'(4));
        if (en_per_out.size() == 4) begin
            check("3x2_taps_i0", 64'(en_per_out[0]), 64'(1));
            check("3x2_taps_i1", 64'(en_per_out[1]), 64'(2));
            check("3x2_taps_i2", 64'(en_per_out[2]), 64'(2));
            check("3x2_taps_i3", 64'(en_per_out[3]), 64'(1));
        end
        check("3x2_pairs_i2", 64'(pairs2.size()), 64'(2));
        if (pairs2.size() == 2) begin
            check("3x2_pair0", 64'(pairs2[0]), 64'(101));
            check("3x2_pair1", 64'(pairs2[1]), 64'(200));
        end

        // Zero X length: load then done only.
        run(0, 5, 1'b0, 1'b0, 0);
        check("0x5_done_cycle", 64'(done_cycle), 64'(2));
        check("0x5_writes", 64'(we_count), 64'(0));
        check("0x5_acc_en", 64'(en_count), 64'(0));

        // Maximum sizes.
        run(31, 31, 1'b0, 1'b0, 0);
        check("max_done_cycle", 64'(done_cycle), 64'(2076));
        check("max_writes", 64'(we_count), 64'(61));
        check("max_last_addr", 64'(last_za), 64'(60));
        check("max_acc_en", 64'(en_count), 64'(961));

        // start held high and sizes scrambled while busy, then back-to-back restart.
        run(2, 3, 1'b1, 1'b1, 0);
        check("held_done_cycle", 64'(done_cycle), 64'(22));
        check("held_writes", 64'(we_count), 64'(4));
        check("held_last_addr", 64'(last_za), 64'(3));
        run(1, 2, 1'b0, 1'b0, 0);
        check("restart_done_cycle", 64'(done_cycle), 64'(10));
        check("restart_writes", 64'(we_count), 64'(2));

        repeat (3) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
